// File: rtl/fetch_decode_pipe.sv
// Pipelined ARM front end: PC register, IF/ID pipeline register, register file
// with PC alias and write-back bypass, and the immediate extender for execute.
module fetch_decode_pipe #(
   parameter int              WIDTH    = 32,
   parameter int              NREGS    = 16,
   parameter logic [WIDTH-1:0] PC_RESET = '0,
   localparam int             RW       = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_f,
   input  logic             flush_d,
   input  logic             pc_src,
   input  logic [WIDTH-1:0] branch_target,
   output logic [WIDTH-1:0] imem_addr,
   input  logic [31:0]      imem_rdata,
   input  logic             wb_en,
   input  logic [RW-1:0]    wb_addr,
   input  logic [WIDTH-1:0] wb_data,
   input  logic [1:0]       reg_src,
   input  logic [1:0]       imm_src,
   output logic             valid_d,
   output logic [31:0]      instr_d,
   output logic [WIDTH-1:0] pc_plus8_d,
   output logic [WIDTH-1:0] src_a_d,
   output logic [WIDTH-1:0] write_data_d,
   output logic [WIDTH-1:0] ext_imm_d
);

   localparam logic [RW-1:0] PC_IDX = RW'(NREGS - 1);

   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] regs [NREGS];
   logic [RW-1:0]    ra1;
   logic [RW-1:0]    ra2;
   logic [WIDTH-1:0] imm24_sx;

   assign imem_addr  = pc;
   assign pc_plus8_d = pc_d + WIDTH'(8);

   // Redirect beats stall so a taken branch is never lost behind a held fetch.
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= PC_RESET;
      end else if (pc_src) begin
         pc <= branch_target;
      end else if (!stall_f) begin
         pc <= pc + WIDTH'(4);
      end
   end

   // A bubble leaves pc_d untouched; only instr/valid are cleared.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_d <= '0;
         pc_d    <= '0;
         valid_d <= 1'b0;
      end else if (flush_d || pc_src) begin
         instr_d <= '0;
         valid_d <= 1'b0;
      end else if (!stall_f) begin
         instr_d <= imem_rdata;
         pc_d    <= pc;
         valid_d <= 1'b1;
      end
   end

   // NOTE: the register array is cleared by reset, so it must map to flops
   // rather than an inferred RAM macro, which has no asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_en && (wb_addr != PC_IDX)) begin
         regs[wb_addr] <= wb_data;
      end
   end

   assign ra1 = reg_src[0] ? PC_IDX : RW'(instr_d[19:16]);
   assign ra2 = reg_src[1] ? RW'(instr_d[15:12]) : RW'(instr_d[3:0]);

   // PC alias first, then the same-cycle write-back bypass, then storage.
   // NOTE: each combinational output gets a default before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      src_a_d = regs[ra1];
      if (ra1 == PC_IDX) begin
         src_a_d = pc_plus8_d;
      end else if (wb_en && (wb_addr == ra1)) begin
         src_a_d = wb_data;
      end
   end

   always_comb begin
      write_data_d = regs[ra2];
      if (ra2 == PC_IDX) begin
         write_data_d = pc_plus8_d;
      end else if (wb_en && (wb_addr == ra2)) begin
         write_data_d = wb_data;
      end
   end

   assign imm24_sx = {{(WIDTH-24){instr_d[23]}}, instr_d[23:0]};

   always_comb begin
      ext_imm_d = '0;
      case (imm_src)
         2'b00:   ext_imm_d = WIDTH'(instr_d[7:0]);
         2'b01:   ext_imm_d = WIDTH'(instr_d[11:0]);
         2'b10:   ext_imm_d = {imm24_sx[WIDTH-3:0], 2'b00};
         default: ext_imm_d = '0;
      endcase
   end

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Directed bench for fetch_decode_pipe: fetch stepping, bypass, PC alias,
// redirect, stall/flush, immediate formats and asynchronous reset.
module tb_fetch_decode_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_f;
   logic        flush_d;
   logic        pc_src;
   logic [31:0] branch_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        wb_en;
   logic [3:0]  wb_addr;
   logic [31:0] wb_data;
   logic [1:0]  reg_src;
   logic [1:0]  imm_src;
   logic        valid_d;
   logic [31:0] instr_d;
   logic [31:0] pc_plus8_d;
   logic [31:0] src_a_d;
   logic [31:0] write_data_d;
   logic [31:0] ext_imm_d;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   fetch_decode_pipe #(.WIDTH(32), .NREGS(16), .PC_RESET(32'h0)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall_f      (stall_f),
      .flush_d      (flush_d),
      .pc_src       (pc_src),
      .branch_target(branch_target),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .wb_en        (wb_en),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .reg_src      (reg_src),
      .imm_src      (imm_src),
      .valid_d      (valid_d),
      .instr_d      (instr_d),
      .pc_plus8_d   (pc_plus8_d),
      .src_a_d      (src_a_d),
      .write_data_d (write_data_d),
      .ext_imm_d    (ext_imm_d)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; stall_f = 1'b0; flush_d = 1'b0; pc_src = 1'b0;
      branch_target = '0; imem_rdata = 32'hE281_1001;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0; reg_src = 2'b00; imm_src = 2'b00;
      #2;
      check("rst_pc",    imem_addr, 32'h0);
      check("rst_valid", {31'b0, valid_d}, 32'h0);
      check("rst_instr", instr_d, 32'h0);
      check("rst_pc8",   pc_plus8_d, 32'h8);
      reset = 1'b0;

      // Free-running fetch.
      step();
      check("run1_pc",    imem_addr, 32'h4);
      check("run1_valid", {31'b0, valid_d}, 32'h1);
      check("run1_instr", instr_d, 32'hE281_1001);
      check("run1_pc8",   pc_plus8_d, 32'h8);
      step();
      check("run2_pc",    imem_addr, 32'h8);
      step();
      check("run3_pc",    imem_addr, 32'hC);
      check("run3_pc8",   pc_plus8_d, 32'h10);

      // Write-back to r1: bypass now, storage next cycle.
      wb_en = 1'b1; wb_addr = 4'd1; wb_data = 32'h1234;
      #1;
      check("byp_srca", src_a_d, 32'h1234);
      check("byp_wd",   write_data_d, 32'h1234);
      step();
      wb_en = 1'b0; wb_data = 32'hFFFF;
      #1;
      check("store_srca", src_a_d, 32'h1234);
      check("run4_pc",    imem_addr, 32'h10);

      // Redirect to 0x100 to set up pc_d for the PC-alias read.
      pc_src = 1'b1; branch_target = 32'h100;
      step();
      check("br100_pc",    imem_addr, 32'h100);
      check("br100_valid", {31'b0, valid_d}, 32'h0);
      pc_src = 1'b0;
      step();
      check("d100_pc8", pc_plus8_d, 32'h108);
      reg_src = 2'b01;
      #1;
      check("alias_srca", src_a_d, 32'h108);
      check("alias_wd",   write_data_d, 32'h1234);
      wb_en = 1'b1; wb_addr = 4'd15; wb_data = 32'hDEAD; stall_f = 1'b1;
      #1;
      check("alias_wb15", src_a_d, 32'h108);
      step();
      wb_en = 1'b0;
      #1;
      check("alias_after", src_a_d, 32'h108);
      check("stall_pc104", imem_addr, 32'h104);
      reg_src = 2'b10;
      #1;
      check("ra2_rd",     write_data_d, 32'h1234);
      reg_src = 2'b00;

      // Redirect while stalled: redirect wins.
      pc_src = 1'b1; branch_target = 32'h40;
      step();
      check("br40_pc",    imem_addr, 32'h40);
      check("br40_valid", {31'b0, valid_d}, 32'h0);
      check("br40_instr", instr_d, 32'h0);
      pc_src = 1'b0; stall_f = 1'b0; imem_rdata = 32'hE3A0_2ABC;
      step();
      check("tgt_instr", instr_d, 32'hE3A0_2ABC);
      check("tgt_valid", {31'b0, valid_d}, 32'h1);
      check("tgt_pc8",   pc_plus8_d, 32'h48);
      check("tgt_pc",    imem_addr, 32'h44);

      // Two stalled cycles, then flush together with stall.
      stall_f = 1'b1; imem_rdata = 32'h1111_1111;
      for (int i = 0; i < 2; i++) begin
         step();
         check("stall_pc",    imem_addr, 32'h44);
         check("stall_instr", instr_d, 32'hE3A0_2ABC);
         check("stall_valid", {31'b0, valid_d}, 32'h1);
      end
      flush_d = 1'b1;
      step();
      check("flush_valid", {31'b0, valid_d}, 32'h0);
      check("flush_instr", instr_d, 32'h0);
      check("flush_pc",    imem_addr, 32'h44);
      check("flush_pc8",   pc_plus8_d, 32'h48);

      // Immediate formats.
      flush_d = 1'b0; stall_f = 1'b0; imem_rdata = 32'hEAFF_FFFE;
      step();
      imm_src = 2'b10;
      #1;
      check("imm_br", ext_imm_d, 32'hFFFF_FFF8);
      imem_rdata = 32'hE3A0_1ABC;
      step();
      imm_src = 2'b01;
      #1;
      check("imm12", ext_imm_d, 32'h0000_0ABC);
      imm_src = 2'b00;
      #1;
      check("imm8", ext_imm_d, 32'h0000_00BC);
      imm_src = 2'b11;
      #1;
      check("imm_zero", ext_imm_d, 32'h0);
      imm_src = 2'b01;

      // Asynchronous reset mid-stream.
      reset = 1'b1;
      #1;
      check("mrst_pc",    imem_addr, 32'h0);
      check("mrst_valid", {31'b0, valid_d}, 32'h0);
      check("mrst_instr", instr_d, 32'h0);
      check("mrst_imm",   ext_imm_d, 32'h0);
      check("mrst_srca",  src_a_d, 32'h0);
      check("mrst_wd",    write_data_d, 32'h0);
      imem_rdata = 32'hE281_1001;
      #1;
      reset = 1'b0;
      step();
      check("post_pc",   imem_addr, 32'h4);
      check("post_pc8",  pc_plus8_d, 32'h8);
      check("post_r1",   src_a_d, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
